muldiv_hilo_unit: RTL

//  Multi-cycle multiply/divide unit with its own HI/LO registers, used in the EX stage.
//  - Replaces the single-cycle ALU multiply path and the separate HI/LO register.
//  - Adds iterative signed/unsigned divide and a parametrised pipelined multiply.
//  - Adds a stall output to the hazard unit and a flush input for cancelled ops.

---
 rtl/muldiv_pkg.sv | 40 ++++
 rtl/muldiv_hilo_unit_if.sv | 34 +++
 rtl/div_radix2_core.sv | 83 ++++++++
 rtl/muldiv_hilo_unit.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// ---------------------------------------------------------------------------
// muldiv_pkg
// Shared definitions for the multiply/divide HI/LO unit:
//   - op encodings driven on op_i by the EX stage
//   - FSM state encodings of the top level
//   - small op-classification helpers used by the unit and its interface
// ---------------------------------------------------------------------------
package muldiv_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    function automatic logic op_is_mul(input logic [OP_W-1:0] op);
        return (op == OP_MULT) || (op == OP_MULTU);
    endfunction

    function automatic logic op_is_div(input logic [OP_W-1:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic op_is_signed(input logic [OP_W-1:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_hilo_unit_if.sv
// ---------------------------------------------------------------------------
// muldiv_hilo_unit_if
// Request/response bundle between the EX stage and the muldiv HI/LO unit.
//   start_i  op request valid        op_i     operation code (muldiv_pkg)
//   a_i/b_i  rs/rt operands          flush_i  abort in-flight op
//   stall_o  hazard-unit stall       done_o   1-cycle completion pulse
//   hi_o     HI register             lo_o     LO register
// master = EX stage side, slave = the unit.
// ---------------------------------------------------------------------------
interface muldiv_hilo_unit_if
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
);
    logic             start_i;
    logic [OP_W-1:0]  op_i;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             flush_i;
    logic             stall_o;
    logic             done_o;
    logic [WIDTH-1:0] hi_o;
    logic [WIDTH-1:0] lo_o;

    modport master (
        output start_i, op_i, a_i, b_i, flush_i,
        input  stall_o, done_o, hi_o, lo_o
    );

    modport slave (
        input  start_i, op_i, a_i, b_i, flush_i,
        output stall_o, done_o, hi_o, lo_o
    );
endinterface

// File: rtl/div_radix2_core.sv
// ---------------------------------------------------------------------------
// div_radix2_core
// Unsigned radix-2 restoring divider, one quotient bit per cycle.
//   clk/rst      clock, synchronous active-high reset
//   start_i      load operands and begin (takes priority over a running divide)
//   dividend_i   unsigned dividend        divisor_i   unsigned divisor
//   quotient_o   quotient                 remainder_o remainder
//   done_o       high during the final iteration; results hold from the
//                following cycle until the next start_i
// A divisor of zero yields an all-ones quotient; the caller overrides it.
// ---------------------------------------------------------------------------
module div_radix2_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o,
    output logic             done_o
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dvs_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;

    logic [WIDTH:0]   shifted_s;
    logic             take_s;
    logic [WIDTH-1:0] rem_nx_s;
    logic             last_s;

    // Trial subtraction: the quotient register doubles as the dividend shifter.
    // When the subtraction is taken the result is below the divisor, so the
    // low WIDTH bits of the difference are exact.
    always_comb begin
        shifted_s = {rem_q, quo_q[WIDTH-1]};
        take_s    = (shifted_s >= {1'b0, dvs_q});
        if (take_s) begin
            rem_nx_s = shifted_s[WIDTH-1:0] - dvs_q;
        end else begin
            rem_nx_s = shifted_s[WIDTH-1:0];
        end
    end

    assign last_s = busy_q && (cnt_q == CNT_LAST);

    // Iteration state: load on start, then one restore step per cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q  <= {WIDTH{1'b0}};
            quo_q  <= {WIDTH{1'b0}};
            dvs_q  <= {WIDTH{1'b0}};
            cnt_q  <= CNT_ZERO;
            busy_q <= 1'b0;
        end else if (start_i) begin
            rem_q  <= {WIDTH{1'b0}};
            quo_q  <= dividend_i;
            dvs_q  <= divisor_i;
            cnt_q  <= CNT_ZERO;
            busy_q <= 1'b1;
        end else if (busy_q) begin
            rem_q  <= rem_nx_s;
            quo_q  <= {quo_q[WIDTH-2:0], take_s};
            cnt_q  <= cnt_q + CNT_ONE;
            busy_q <= !last_s;
        end else begin
            busy_q <= 1'b0;
        end
    end

    assign quotient_o  = quo_q;
    assign remainder_o = rem_q;
    assign done_o      = last_s;

endmodule

// File: rtl/muldiv_hilo_unit.sv
// ---------------------------------------------------------------------------
// muldiv_hilo_unit
// Multi-cycle multiply/divide unit owning the HI/LO registers (EX stage).
//   clk   clock             rst   synchronous active-high reset
//   bus   muldiv_hilo_unit_if.slave (start/op/a/b/flush in; stall/done/hi/lo out)
// MULT/MULTU finish MUL_STAGES+1 cycles after the start edge, DIV/DIVU
// WIDTH+1 cycles after it; MTHI/MTLO write in a single cycle without stalling.
// HI/LO are written on the edge that ends the DONE cycle (done_o high).
// ---------------------------------------------------------------------------
module muldiv_hilo_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int MUL_STAGES = 2
) (
    input logic               clk,
    input logic               rst,
    muldiv_hilo_unit_if.slave bus
);
    localparam int MCNT_W = (MUL_STAGES > 1) ? $clog2(MUL_STAGES) : 1;
    localparam logic [MCNT_W-1:0] MCNT_LAST = MCNT_W'(MUL_STAGES - 1);
    localparam logic [MCNT_W-1:0] MCNT_ONE  = MCNT_W'(1);
    localparam logic [MCNT_W-1:0] MCNT_ZERO = MCNT_W'(0);
    localparam logic [WIDTH-1:0]  ALL_ONES  = {WIDTH{1'b1}};

    function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? (-v) : v;
    endfunction

    state_e             state_q, state_d;
    logic [MCNT_W-1:0]  mcnt_q, mcnt_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    // Operands carry one extra sign bit: zero for unsigned ops, so the same
    // datapath serves MULT/MULTU and the signed/unsigned divide fixup.
    logic [WIDTH:0]     opa_q, opb_q;
    logic               is_div_q;
    logic               bzero_q;
    logic [2*WIDTH-1:0] prod_q [MUL_STAGES];

    logic [OP_W-1:0]    op_s;
    logic               sgn_s;
    logic               accept_s;
    logic               muldiv_accept_s;
    logic               div_start_s;
    logic [WIDTH-1:0]   dividend_s, divisor_s;
    logic [2*WIDTH-1:0] mul_a_s, mul_b_s;
    logic [WIDTH-1:0]   quo_s, rem_s;
    logic               div_last_s;
    logic [WIDTH-1:0]   res_hi_s, res_lo_s;
    logic               done_s;
    logic               stall_s;

    assign op_s            = bus.op_i;
    assign sgn_s           = op_is_signed(op_s);
    // flush_i outranks a new request presented in the same cycle.
    assign accept_s        = (state_q == ST_IDLE) && bus.start_i && !bus.flush_i;
    assign muldiv_accept_s = accept_s && (op_is_mul(op_s) || op_is_div(op_s));
    assign div_start_s     = accept_s && op_is_div(op_s);
    assign dividend_s      = sgn_s ? abs_val(bus.a_i) : bus.a_i;
    assign divisor_s       = sgn_s ? abs_val(bus.b_i) : bus.b_i;

    // Only the low 2*WIDTH product bits are kept, so sign-extending the
    // latched operands to 2*WIDTH and multiplying modulo 2^(2*WIDTH) is exact.
    assign mul_a_s = {{(WIDTH-1){opa_q[WIDTH]}}, opa_q};
    assign mul_b_s = {{(WIDTH-1){opb_q[WIDTH]}}, opb_q};

    div_radix2_core #(.WIDTH(WIDTH)) u_div (
        .clk         (clk),
        .rst         (rst),
        .start_i     (div_start_s),
        .dividend_i  (dividend_s),
        .divisor_i   (divisor_s),
        .quotient_o  (quo_s),
        .remainder_o (rem_s),
        .done_o      (div_last_s)
    );

    // Result selection for the DONE cycle, including divide sign fixup.
    always_comb begin
        res_hi_s = hi_q;
        res_lo_s = lo_q;
        if (is_div_q) begin
            if (bzero_q) begin
                res_hi_s = opa_q[WIDTH-1:0];
                res_lo_s = ALL_ONES;
            end else begin
                res_hi_s = opa_q[WIDTH] ? (-rem_s) : rem_s;
                res_lo_s = (opa_q[WIDTH] ^ opb_q[WIDTH]) ? (-quo_s) : quo_s;
            end
        end else begin
            res_hi_s = prod_q[MUL_STAGES-1][2*WIDTH-1:WIDTH];
            res_lo_s = prod_q[MUL_STAGES-1][WIDTH-1:0];
        end
    end

    // FSM next state, multiply cycle counter and HI/LO write data.
    always_comb begin
        state_d = state_q;
        mcnt_d  = mcnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    case (op_s)
                        OP_MULT, OP_MULTU: begin
                            state_d = ST_MUL;
                            mcnt_d  = MCNT_ZERO;
                        end
                        OP_DIV, OP_DIVU: state_d = ST_DIV;
                        OP_MTHI:         hi_d    = bus.a_i;
                        OP_MTLO:         lo_d    = bus.a_i;
                        default:         state_d = ST_IDLE;
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MUL: begin
                if (bus.flush_i) begin
                    state_d = ST_IDLE;
                end else if (mcnt_q == MCNT_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    mcnt_d = mcnt_q + MCNT_ONE;
                end
            end
            ST_DIV: begin
                if (bus.flush_i) begin
                    state_d = ST_IDLE;
                end else if (div_last_s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_DIV;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                if (!bus.flush_i) begin
                    done_s = 1'b1;
                    hi_d   = res_hi_s;
                    lo_d   = res_lo_s;
                end else begin
                    done_s = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, counter and HI/LO registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            mcnt_q  <= MCNT_ZERO;
            hi_q    <= {WIDTH{1'b0}};
            lo_q    <= {WIDTH{1'b0}};
        end else begin
            state_q <= state_d;
            mcnt_q  <= mcnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // Operand capture for a multiply or divide accepted from IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            opa_q    <= {(WIDTH+1){1'b0}};
            opb_q    <= {(WIDTH+1){1'b0}};
            is_div_q <= 1'b0;
            bzero_q  <= 1'b0;
        end else if (muldiv_accept_s) begin
            opa_q    <= {sgn_s & bus.a_i[WIDTH-1], bus.a_i};
            opb_q    <= {sgn_s & bus.b_i[WIDTH-1], bus.b_i};
            is_div_q <= op_is_div(op_s);
            bzero_q  <= (bus.b_i == {WIDTH{1'b0}});
        end else begin
            is_div_q <= is_div_q;
        end
    end

    // Product pipeline; its last stage is valid in the DONE cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MUL_STAGES; i++) begin
                prod_q[i] <= {(2*WIDTH){1'b0}};
            end
        end else begin
            prod_q[0] <= mul_a_s * mul_b_s;
            for (int i = 1; i < MUL_STAGES; i++) begin
                prod_q[i] <= prod_q[i-1];
            end
        end
    end

    // Stall covers the issuing cycle in IDLE and every busy cycle, and drops
    // in DONE so the instruction leaves EX exactly once.
    assign stall_s = (state_q == ST_MUL) || (state_q == ST_DIV) ||
                     ((state_q == ST_IDLE) && bus.start_i &&
                      (op_is_mul(op_s) || op_is_div(op_s)));

    assign bus.stall_o = stall_s;
    assign bus.done_o  = done_s;
    assign bus.hi_o    = hi_q;
    assign bus.lo_o    = lo_q;

endmodule
